// File: rtl/fp32_pkg.sv
// fp32_pkg: shared constants, field helpers and FSM states
// for the sequential binary32 divider.
package fp32_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int MANT_W   = FRAC_W + 1;
    localparam int QBITS    = 26;
    localparam int LATENCY  = 28;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    localparam logic signed [9:0] BIAS10 = 10'sd127;

    typedef enum logic [1:0] {
        S_IDLE,
        S_UNPACK,
        S_DIVIDE,
        S_ROUND
    } state_e;

    function automatic logic f_sign(input logic [31:0] x);
        return x[31];
    endfunction

    function automatic logic [EXP_W-1:0] f_exp(input logic [31:0] x);
        return x[30:23];
    endfunction

    function automatic logic [FRAC_W-1:0] f_frac(input logic [31:0] x);
        return x[22:0];
    endfunction

endpackage

// File: rtl/fp32_mant_div.sv
// fp32_mant_div: 24-bit restoring divider, one quotient bit
// per step, integer bit first, sticky from the final remainder.
import fp32_pkg::*;

module fp32_mant_div (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [MANT_W-1:0] dividend_i,
    input  logic [MANT_W-1:0] divisor_i,
    output logic [QBITS-1:0]  quot_o,
    output logic              sticky_o
);

    logic [MANT_W:0]   rem_q;
    logic [MANT_W-1:0] div_q;
    logic [QBITS-1:0]  quot_q;
    logic              ge;
    logic [MANT_W-1:0] rem_n;

    // Trial subtraction; partial remainder stays below 2*divisor
    always_comb begin
        ge    = rem_q >= {1'b0, div_q};
        rem_n = rem_q[MANT_W-1:0];
        if (ge) begin
            rem_n = MANT_W'(rem_q - {1'b0, div_q});
        end
    end

    // Load operands, then shift in one quotient bit per step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            div_q  <= '0;
            quot_q <= '0;
        end else if (load_i) begin
            rem_q  <= {1'b0, dividend_i};
            div_q  <= divisor_i;
            quot_q <= '0;
        end else if (step_i) begin
            quot_q <= {quot_q[QBITS-2:0], ge};
            rem_q  <= {rem_n, 1'b0};
        end
    end

    assign quot_o   = quot_q;
    assign sticky_o = |rem_q;

endmodule

// File: rtl/fp32_divide.sv
// fp32_divide: sequential binary32 divider, RNE rounding,
// flush-to-zero inputs, fixed 28-clock start-to-done latency.
import fp32_pkg::*;

module fp32_divide (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  flags
);

    state_e state_q, state_d;
    logic [4:0]  cnt_q;
    logic [31:0] a_q, b_q;
    logic        special_q;
    logic [31:0] spec_res_q;
    logic [4:0]  spec_flags_q;
    logic        sign_q;
    logic signed [9:0] exp_q;
    logic [31:0] result_q;
    logic [4:0]  flags_q;
    logic        done_q;

    logic accept, div_load, div_step, round_en;

    logic [QBITS-1:0] quot;
    logic             sticky;

    logic        un_special;
    logic [31:0] un_res;
    logic [4:0]  un_flags;
    logic        un_sign;
    logic signed [9:0] un_exp;

    logic [31:0] rd_res;
    logic [4:0]  rd_flags;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: fixed sequence, DIVIDE runs QBITS clocks
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_UNPACK;
            S_UNPACK: state_d = S_DIVIDE;
            S_DIVIDE: if (cnt_q == 5'(QBITS-1)) state_d = S_ROUND;
            S_ROUND:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State-decoded control strobes
    always_comb begin
        busy     = state_q != S_IDLE;
        accept   = (state_q == S_IDLE) && start;
        div_load = state_q == S_UNPACK;
        div_step = state_q == S_DIVIDE;
        round_en = state_q == S_ROUND;
    end

    // Step counter for the divide phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        cnt_q <= '0;
        else if (div_load) cnt_q <= '0;
        else if (div_step) cnt_q <= cnt_q + 5'd1;
    end

    fp32_mant_div u_mdiv (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (div_load),
        .step_i     (div_step),
        .dividend_i ({1'b1, f_frac(a_q)}),
        .divisor_i  ({1'b1, f_frac(b_q)}),
        .quot_o     (quot),
        .sticky_o   (sticky)
    );

    // Classify operands; specials still run the divider for fixed latency
    always_comb begin
        logic [7:0] ea, eb;
        logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        ea      = f_exp(a_q);
        eb      = f_exp(b_q);
        a_nan   = (ea == 8'hFF) && (f_frac(a_q) != '0);
        b_nan   = (eb == 8'hFF) && (f_frac(b_q) != '0);
        a_inf   = (ea == 8'hFF) && (f_frac(a_q) == '0);
        b_inf   = (eb == 8'hFF) && (f_frac(b_q) == '0);
        a_zero  = ea == 8'h00;
        b_zero  = eb == 8'h00;
        un_sign = f_sign(a_q) ^ f_sign(b_q);
        un_exp  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS10;
        un_special = 1'b1;
        un_res     = '0;
        un_flags   = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            un_res   = QNAN;
            un_flags = 5'b10000;
        end else if (a_inf) begin
            un_res = {un_sign, POS_INF[30:0]};
        end else if (b_zero) begin
            un_res   = {un_sign, POS_INF[30:0]};
            un_flags = 5'b01000;
        end else if (a_zero || b_inf) begin
            un_res = {un_sign, 31'b0};
        end else begin
            un_special = 1'b0;
        end
    end

    // Normalise, round to nearest even, range-check and pack
    always_comb begin
        logic [MANT_W-1:0] mant;
        logic [MANT_W:0]   sum;
        logic [MANT_W-1:0] mant_r;
        logic g, r, inc;
        logic signed [9:0] e;
        if (quot[QBITS-1]) begin
            mant = quot[QBITS-1:2];
            g    = quot[1];
            r    = quot[0];
            e    = exp_q;
        end else begin
            mant = quot[QBITS-2:1];
            g    = quot[0];
            r    = 1'b0;
            e    = exp_q - 10'sd1;
        end
        inc = g & (r | sticky | mant[0]);
        sum = {1'b0, mant} + {{MANT_W{1'b0}}, inc};
        if (sum[MANT_W]) begin
            mant_r = sum[MANT_W:1];
            e      = e + 10'sd1;
        end else begin
            mant_r = sum[MANT_W-1:0];
        end
        rd_res   = {sign_q, e[7:0], mant_r[FRAC_W-1:0]};
        rd_flags = {4'b0000, g | r | sticky};
        if (special_q) begin
            rd_res   = spec_res_q;
            rd_flags = spec_flags_q;
        end else if (e >= 10'sd255) begin
            rd_res   = {sign_q, POS_INF[30:0]};
            rd_flags = 5'b00101;
        end else if (e <= 10'sd0) begin
            rd_res   = {sign_q, 31'b0};
            rd_flags = 5'b00011;
        end
    end

    // Operand capture and unpacked-operand registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            special_q    <= 1'b0;
            spec_res_q   <= '0;
            spec_flags_q <= '0;
            sign_q       <= 1'b0;
            exp_q        <= '0;
        end else begin
            if (accept) begin
                a_q <= a;
                b_q <= b;
            end
            if (div_load) begin
                special_q    <= un_special;
                spec_res_q   <= un_res;
                spec_flags_q <= un_flags;
                sign_q       <= un_sign;
                exp_q        <= un_exp;
            end
        end
    end

    // Result/flags held until next round; done is a one-cycle pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= round_en;
            if (round_en) begin
                result_q <= rd_res;
                flags_q  <= rd_flags;
            end
        end
    end

    assign done   = done_q;
    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_fp32_divide.sv
// tb_fp32_divide: directed vectors with hand-computed quotients,
// latency, busy, back-to-back and reset-abort checks.
module tb_fp32_divide;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  flags;

    int n_cmp;
    int n_bad;

    fp32_divide dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flags  (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Start at edge T; done must appear exactly after edge T+28.
    // poke drives a second start while busy, which must be ignored.
    task automatic run_div(input string tag, input logic [31:0] ia,
                           input logic [31:0] ib, input logic [31:0] er,
                           input logic [4:0] ef, input bit poke);
        int early;
        early = 0;
        @(negedge clk);
        start = 1'b1;
        a     = ia;
        b     = ib;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, ".busy_t1"}, 32'(busy), 32'd1);
        for (int i = 1; i < 28; i++) begin
            @(posedge clk);
            #1;
            if (done) early++;
            if (poke && i == 4) begin
                start = 1'b1;
                a     = 32'h3F800000;
                b     = 32'h40000000;
            end
            if (poke && i == 5) start = 1'b0;
        end
        check({tag, ".early_done"}, 32'(early), 32'd0);
        check({tag, ".busy_t27"}, 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".busy_t28"}, 32'(busy), 32'd0);
        check({tag, ".result"}, result, er);
        check({tag, ".flags"}, 32'(flags), 32'(ef));
    endtask

    initial begin
        int dcnt;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #17;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.result", result, 32'h0);
        check("rst.flags", 32'(flags), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Chained runs: each start lands in the previous done cycle
        run_div("r1p25", 32'h3FA00000, 32'h3F400000, 32'h3FD55555, 5'b00001, 0);
        run_div("rne_up", 32'h411C0000, 32'hBF100000, 32'hC18AAAAB, 5'b00001, 0);
        run_div("zz", 32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 0);
        run_div("dbz", 32'h3F800000, 32'h80000000, 32'hFF800000, 5'b01000, 0);
        run_div("ovf", 32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 5'b00101, 0);
        run_div("unf", 32'h00800000, 32'h7F7FFFFF, 32'h00000000, 5'b00011, 0);
        run_div("six3", 32'h40C00000, 32'h40400000, 32'h40000000, 5'b00000, 1);
        run_div("inf_a", 32'h7F800000, 32'hC0000000, 32'hFF800000, 5'b00000, 0);
        run_div("nan_a", 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b10000, 0);
        run_div("infinf", 32'hFF800000, 32'h7F800000, 32'h7FC00000, 5'b10000, 0);
        run_div("zero_a", 32'h00000000, 32'hC0000000, 32'h80000000, 5'b00000, 0);
        run_div("inf_b", 32'h3F800000, 32'hFF800000, 32'h80000000, 5'b00000, 0);
        run_div("subn_a", 32'h00000001, 32'h3F800000, 32'h00000000, 5'b00000, 0);
        run_div("one", 32'h3F800000, 32'h3F800000, 32'h3F800000, 5'b00000, 0);

        // done is a single pulse and the result is held afterwards
        @(posedge clk);
        #1;
        check("pulse.done", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("hold.result", result, 32'h3F800000);

        // Reset at T+10 aborts with no done pulse
        @(negedge clk);
        start = 1'b1;
        a     = 32'h3FA00000;
        b     = 32'h3F400000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        check("abort.result", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
        end
        check("abort.no_done", 32'(dcnt), 32'd0);
        run_div("post_rst", 32'h411C0000, 32'hBF100000, 32'hC18AAAAB, 5'b00001, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
